// File: rtl/icache_responder_if.sv
// Fetch-side request/response bundle between the fetch stage and the instruction cache.
// Fetch holds imemREN/imemaddr steady until ihit. ihit marks imemload valid for that cycle only, and the response has no back-pressure.
interface icache_responder_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;

  modport master (
    output imemREN, imemaddr, flush,
    input  ihit, imemload
  );

  modport slave (
    input  imemREN, imemaddr, flush,
    output ihit, imemload
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache.
// A miss is refilled by a single-word read from the memory controller, then answered as a hit.
module icache_responder #(
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  icache_responder_if.slave fif,
  output logic              iREN,
  output logic [31:0]       iaddr,
  input  logic              iwait,
  input  logic [31:0]       iload,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic              dbg_fetch
);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 30 - IDX;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t           state, next_state;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_arr [SETS];
  logic [31:0]      data_arr [SETS];
  logic [31:0]      maddr;
  logic [IDX-1:0]   idx, midx;
  logic [TAG_W-1:0] tag, mtag;
  logic             hit, miss, fill;
  logic [1:0]       unused_offset;

  assign idx           = fif.imemaddr[IDX+1:2];
  assign tag           = fif.imemaddr[31:IDX+2];
  assign midx          = maddr[IDX+1:2];
  assign mtag          = maddr[31:IDX+2];
  assign unused_offset = fif.imemaddr[1:0];

  assign hit  = (state == IDLE) && fif.imemREN && valid[idx] && (tag_arr[idx] == tag);
  assign miss = (state == IDLE) && fif.imemREN && !hit;
  assign fill = (state == FETCH) && !iwait;

  assign dbg_fetch = (state == FETCH);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (miss) next_state = FETCH;
      FETCH: if (!iwait) next_state = IDLE;
    endcase
  end

  // A flush cycle suppresses the hit response even though the line is still valid.
  always_comb begin
    iREN         = 1'b0;
    iaddr        = '0;
    fif.ihit     = 1'b0;
    fif.imemload = '0;
    case (state)
      IDLE: begin
        if (hit && !fif.flush) begin
          fif.ihit     = 1'b1;
          fif.imemload = data_arr[idx];
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = maddr;
      end
    endcase
  end

  // Flush is applied after the fill so it wins when both land on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && !fif.flush)  hit_count  <= hit_count + CNT_W'(1);
      if (miss && !fif.flush) miss_count <= miss_count + CNT_W'(1);
      if (fill)               valid[midx] <= 1'b1;
      if (fif.flush)          valid <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (miss) maddr <= {fif.imemaddr[31:2], 2'b00};
    if (fill) begin
      data_arr[midx] <= iload;
      tag_arr[midx]  <= mtag;
    end
  end
endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: a default build plus a CNT_W=4 build for counter wrap.
module tb_icache_responder;
  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic        dbg_fetch;

  logic        s_rst;
  logic        s_iren;
  logic [31:0] s_iaddr;
  logic        s_iwait;
  logic [31:0] s_iload;
  logic [3:0]  s_hit_count;
  logic [3:0]  s_miss_count;
  logic        s_dbg_fetch;

  int n_checks = 0;
  int n_fail   = 0;

  icache_responder_if fif ();
  icache_responder_if s_if ();

  icache_responder #(.SETS(16), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .fif(fif),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count), .dbg_fetch(dbg_fetch)
  );

  icache_responder #(.SETS(4), .CNT_W(4)) dut_small (
    .CLK(CLK), .RST(s_rst), .fif(s_if),
    .iREN(s_iren), .iaddr(s_iaddr), .iwait(s_iwait), .iload(s_iload),
    .hit_count(s_hit_count), .miss_count(s_miss_count), .dbg_fetch(s_dbg_fetch)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a missing request through FETCH; returns in the following IDLE cycle, request still held.
  task automatic miss_fill(input logic [31:0] addr, input logic [31:0] data, input int waits);
    fif.imemREN  = 1'b1;
    fif.imemaddr = addr;
    iwait        = 1'b1;
    #1;
    chk("miss_no_hit", {31'b0, fif.ihit}, 32'd0);
    chk("miss_iren_idle", {31'b0, iREN}, 32'd0);
    tick();
    for (int w = 0; w < waits; w++) begin
      #1;
      chk("wait_iren", {31'b0, iREN}, 32'd1);
      chk("wait_iaddr", iaddr, addr & 32'hFFFF_FFFC);
      tick();
    end
    iwait = 1'b0;
    iload = data;
    #1;
    chk("fill_iren", {31'b0, iREN}, 32'd1);
    chk("fill_iaddr", iaddr, addr & 32'hFFFF_FFFC);
    chk("fill_no_hit", {31'b0, fif.ihit}, 32'd0);
    tick();
    iwait = 1'b1;
    iload = 32'd0;
    #1;
  endtask

  initial begin
    RST = 1'b1; s_rst = 1'b1;
    fif.imemREN = 1'b0; fif.imemaddr = 32'd0; fif.flush = 1'b0;
    s_if.imemREN = 1'b0; s_if.imemaddr = 32'd0; s_if.flush = 1'b0;
    iwait = 1'b1; iload = 32'd0; s_iwait = 1'b1; s_iload = 32'd0;
    repeat (2) tick();
    RST = 1'b0; s_rst = 1'b0;
    #1;
    chk("rst_ihit", {31'b0, fif.ihit}, 32'd0);
    chk("rst_iren", {31'b0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_imemload", fif.imemload, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    chk("rst_state", {31'b0, dbg_fetch}, 32'd0);

    // first miss on 0x40 with two wait cycles
    miss_fill(32'h40, 32'h2008_0001, 2);
    chk("t1_ihit", {31'b0, fif.ihit}, 32'd1);
    chk("t1_load", fif.imemload, 32'h2008_0001);
    chk("t1_iren_off", {31'b0, iREN}, 32'd0);
    chk("t1_misses", miss_count, 32'd1);
    chk("t1_hits_pre", hit_count, 32'd0);
    tick();
    fif.imemREN = 1'b0;
    #1;
    chk("t1_hits", hit_count, 32'd1);
    chk("t1_idle_ihit", {31'b0, fif.ihit}, 32'd0);
    chk("t1_idle_load", fif.imemload, 32'd0);

    // re-read hits at once; conflicting tag evicts
    fif.imemREN = 1'b1; fif.imemaddr = 32'h40;
    #1;
    chk("t2_ihit", {31'b0, fif.ihit}, 32'd1);
    chk("t2_iren", {31'b0, iREN}, 32'd0);
    chk("t2_load", fif.imemload, 32'h2008_0001);
    tick();
    fif.imemREN = 1'b0;
    #1;
    chk("t2_hits", hit_count, 32'd2);
    miss_fill(32'h440, 32'h1111_1111, 0);
    chk("t2_conf_ihit", {31'b0, fif.ihit}, 32'd1);
    chk("t2_conf_load", fif.imemload, 32'h1111_1111);
    tick();
    fif.imemREN = 1'b0;
    #1;
    chk("t2_conf_hits", hit_count, 32'd3);
    chk("t2_conf_misses", miss_count, 32'd2);
    miss_fill(32'h40, 32'h2008_0001, 1);
    chk("t2_back_ihit", {31'b0, fif.ihit}, 32'd1);
    tick();
    fif.imemREN = 1'b0;
    #1;
    chk("t2_back_hits", hit_count, 32'd4);
    chk("t2_back_misses", miss_count, 32'd3);

    // address change while FETCH is in flight
    fif.imemREN = 1'b1; fif.imemaddr = 32'h80; iwait = 1'b1;
    #1;
    chk("t3_miss", {31'b0, fif.ihit}, 32'd0);
    tick();
    fif.imemaddr = 32'h84;
    #1;
    chk("t3_iaddr_latched", iaddr, 32'h80);
    chk("t3_iren", {31'b0, iREN}, 32'd1);
    chk("t3_state", {31'b0, dbg_fetch}, 32'd1);
    chk("t3_misses_a", miss_count, 32'd4);
    iwait = 1'b0; iload = 32'hAAAA_0080;
    tick();
    iwait = 1'b1; iload = 32'd0;
    #1;
    chk("t3_84_miss", {31'b0, fif.ihit}, 32'd0);
    chk("t3_84_iren", {31'b0, iREN}, 32'd0);
    tick();
    #1;
    chk("t3_84_iaddr", iaddr, 32'h84);
    chk("t3_misses_b", miss_count, 32'd5);
    iwait = 1'b0; iload = 32'hBBBB_0084;
    tick();
    iwait = 1'b1; iload = 32'd0;
    #1;
    chk("t3_84_hit", {31'b0, fif.ihit}, 32'd1);
    chk("t3_84_load", fif.imemload, 32'hBBBB_0084);
    tick();
    fif.imemaddr = 32'h80;
    #1;
    chk("t3_80_hit", {31'b0, fif.ihit}, 32'd1);
    chk("t3_80_load", fif.imemload, 32'hAAAA_0080);
    chk("t3_hits", hit_count, 32'd5);
    tick();
    fif.imemREN = 1'b0;
    #1;
    chk("t3_hits_b", hit_count, 32'd6);

    // flush on a valid line, then flush on the fill edge
    miss_fill(32'h40, 32'h2008_0001, 0);
    chk("t4_hit", {31'b0, fif.ihit}, 32'd1);
    tick();
    fif.flush = 1'b1;
    #1;
    chk("t4_flush_ihit", {31'b0, fif.ihit}, 32'd0);
    chk("t4_flush_load", fif.imemload, 32'd0);
    tick();
    fif.flush = 1'b0;
    #1;
    chk("t4_flush_nocount", hit_count, 32'd7);
    chk("t4_after_flush_miss", {31'b0, fif.ihit}, 32'd0);
    tick();
    #1;
    chk("t4_refetch_iren", {31'b0, iREN}, 32'd1);
    chk("t4_misses", miss_count, 32'd7);
    iwait = 1'b0; iload = 32'h2008_0001; fif.flush = 1'b1;
    #1;
    chk("t4_fillflush_ihit", {31'b0, fif.ihit}, 32'd0);
    tick();
    fif.flush = 1'b0; iwait = 1'b1; iload = 32'd0;
    #1;
    chk("t4_fillflush_state", {31'b0, dbg_fetch}, 32'd0);
    chk("t4_fillflush_invalid", {31'b0, fif.ihit}, 32'd0);
    tick();
    #1;
    chk("t4_misses_b", miss_count, 32'd8);
    chk("t4_iren_b", {31'b0, iREN}, 32'd1);
    iwait = 1'b0; iload = 32'h2008_0001;
    tick();
    iwait = 1'b1; iload = 32'd0;
    #1;
    chk("t4_refill_hit", {31'b0, fif.ihit}, 32'd1);
    tick();
    fif.imemaddr = 32'h84;
    #1;
    chk("t4_84_flushed", {31'b0, fif.ihit}, 32'd0);
    tick();
    #1;
    chk("t4_84_iaddr", iaddr, 32'h84);

    // reset in the middle of a FETCH
    RST = 1'b1;
    tick();
    #1;
    chk("t5_iren", {31'b0, iREN}, 32'd0);
    chk("t5_iaddr", iaddr, 32'd0);
    chk("t5_state", {31'b0, dbg_fetch}, 32'd0);
    chk("t5_hits", hit_count, 32'd0);
    chk("t5_misses", miss_count, 32'd0);
    fif.imemaddr = 32'h40;
    #1;
    chk("t5_line_invalid", {31'b0, fif.ihit}, 32'd0);
    RST = 1'b0; fif.imemREN = 1'b0;
    tick();
    #1;
    chk("t5_misses_idle", miss_count, 32'd0);

    // 4-bit counter wrap on the small build
    s_if.imemREN = 1'b1; s_if.imemaddr = 32'h10; s_iwait = 1'b0; s_iload = 32'h5A5A_5A5A;
    #1;
    chk("t6_first_miss", {31'b0, s_if.ihit}, 32'd0);
    tick();
    #1;
    chk("t6_iren", {31'b0, s_iren}, 32'd1);
    tick();
    #1;
    chk("t6_hit", {31'b0, s_if.ihit}, 32'd1);
    chk("t6_load", s_if.imemload, 32'h5A5A_5A5A);
    chk("t6_hits0", {28'b0, s_hit_count}, 32'd0);
    chk("t6_misses", {28'b0, s_miss_count}, 32'd1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      #1;
      chk("t6_hits_inc", {28'b0, s_hit_count}, 32'(i));
    end
    tick();
    #1;
    chk("t6_wrap", {28'b0, s_hit_count}, 32'd0);
    s_if.imemREN = 1'b0;
    tick();
    #1;
    chk("t6_misses_final", {28'b0, s_miss_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
